// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back front end.
// Default widths match the 32 x 32-bit CPU register file.
package regfile_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LD : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order write queue: one push and one pop per clock, with an in-place overwrite of the youngest entry.
// Entries are presented oldest-first with valid bits so the owner can run an age-ordered search.
module regfile_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [W-1:0]                  push_dat,
  input  logic                          pop,
  input  logic                          coal,
  input  logic [W-1:0]                  coal_dat,
  output logic [W-1:0]                  head,
  output logic [DEPTH-1:0][W-1:0]       ent,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];

  always_comb begin
    rd_d  = rd_q + PW'(pop);
    wr_d  = wr_q + PW'(push);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: validity is tracked solely by the count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= push_dat;
    if (coal) mem_q[wr_q - PW'(1)] <= coal_dat;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent[i]     = mem_q[rd_q + PW'(i)];
      ent_vld[i] = (PW+1)'(i) < cnt_q;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write front end: round-robin ALU/load arbitration into a FIFO, registered write port
// two edges after acceptance, and a youngest-wins bypass. REGFILE_WB_COALESCE_EN enables youngest-entry merge.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_wr,
  input  logic [DATA_W-1:0] alu_wd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_wr,
  input  logic [DATA_W-1:0] ld_wd,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] byp_rr1,
  input  logic [ADDR_W-1:0] byp_rr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
  output logic              full,
  output logic              empty
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t                   head, sel, load_e, byp_e;
  logic [DEPTH-1:0][EW-1:0] ent_flat;
  logic [DEPTH-1:0]         ent_vld;
  logic [CW-1:0]            count;
  logic                     fifo_full, fifo_empty;

  logic req_alu, req_ld, gnt_alu, gnt_ld, coal_alu, coal_ld, coal, push;
  src_e prio_q, prio_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;

`ifdef REGFILE_WB_COALESCE_EN
  entry_t          youngest;
  logic [CW-2:0]   yidx;
  assign yidx     = (CW-1)'(count - CW'(1));
  assign youngest = entry_t'(ent_flat[yidx]);
  assign coal_alu = (alu_wr != '0) && !fifo_empty && (youngest.addr == alu_wr);
  assign coal_ld  = (ld_wr  != '0) && !fifo_empty && (youngest.addr == ld_wr);
`else
  assign coal_alu = 1'b0;
  assign coal_ld  = 1'b0;
`endif

  // A merge needs no free slot, so it may be granted while full.
  always_comb begin
    req_alu = alu_valid && (!fifo_full || coal_alu);
    req_ld  = ld_valid  && (!fifo_full || coal_ld);
    gnt_alu = req_alu && (!req_ld  || prio_q == SRC_ALU);
    gnt_ld  = req_ld  && (!req_alu || prio_q == SRC_LD);
    prio_d  = (req_alu && req_ld) ? other_src(prio_q) : prio_q;
    sel     = gnt_ld ? entry_t'{ld_wr, ld_wd} : entry_t'{alu_wr, alu_wd};
    coal    = (gnt_alu && coal_alu) || (gnt_ld && coal_ld);
    push    = (gnt_alu || gnt_ld) && (sel.addr != '0) && !coal;
  end

  assign alu_ready = gnt_alu;
  assign ld_ready  = gnt_ld;

  regfile_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (sel),
    .pop      (!fifo_empty),
    .coal     (coal),
    .coal_dat (sel),
    .head     (head),
    .ent      (ent_flat),
    .ent_vld  (ent_vld),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Merging into a lone entry that pops this edge must reach the output stage directly.
  always_comb begin
    rw_d   = !fifo_empty;
    wr_d   = wr_q;
    wd_d   = wd_q;
    load_e = head;
    if (coal && count == CW'(1)) load_e = sel;
    if (!fifo_empty) begin
      wr_d = load_e.addr;
      wd_d = load_e.data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q <= SRC_ALU;
      rw_q   <= 1'b0;
      wr_q   <= '0;
      wd_q   <= '0;
    end else begin
      prio_q <= prio_d;
      rw_q   <= rw_d;
      wr_q   <= wr_d;
      wd_q   <= wd_d;
    end
  end

  assign RegWrite = rw_q;
  assign WR       = wr_q;
  assign WD       = wd_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;

  // Scan oldest to youngest so later matches override earlier ones.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    byp_e     = '0;
    if (rw_q && wr_q == byp_rr1) begin
      byp_hit1  = 1'b1;
      byp_data1 = wd_q;
    end
    if (rw_q && wr_q == byp_rr2) begin
      byp_hit2  = 1'b1;
      byp_data2 = wd_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      byp_e = entry_t'(ent_flat[i]);
      if (ent_vld[i] && byp_e.addr == byp_rr1) begin
        byp_hit1  = 1'b1;
        byp_data1 = byp_e.data;
      end
      if (ent_vld[i] && byp_e.addr == byp_rr2) begin
        byp_hit2  = 1'b1;
        byp_data2 = byp_e.data;
      end
    end
    if (byp_rr1 == '0) begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
    end
    if (byp_rr2 == '0) begin
      byp_hit2  = 1'b0;
      byp_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid;
  logic          alu_ready, ld_ready;
  logic [AW-1:0] alu_wr, ld_wr, byp_rr1, byp_rr2, WR;
  logic [DW-1:0] alu_wd, ld_wd, WD, byp_data1, byp_data2;
  logic          RegWrite, byp_hit1, byp_hit2, full, empty;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wr(alu_wr), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr(ld_wr), .ld_wd(ld_wd),
    .RegWrite(RegWrite), .WR(WR), .WD(WD),
    .byp_rr1(byp_rr1), .byp_rr2(byp_rr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t alu_src[$], ld_src[$];
  ent_t mq[$];
  ent_t exp_out[$];
  ent_t m_out;
  bit   m_out_vld = 0;
  bit   m_prio_ld = 0;
  bit   hold_a = 0, hold_l = 0;
  int   pa = 100, pl = 100;
  int   errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void byp_model(input logic [AW-1:0] rr, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d = '0;
    if (rr == 0) return;
    if (m_out_vld && m_out.a == rr) begin
      hit = 1;
      d = m_out.d;
    end
    foreach (mq[i]) begin
      if (mq[i].a == rr) begin
        hit = 1;
        d = mq[i].d;
      end
    end
  endfunction

  always @(negedge clock) begin
    if (RegWrite === 1'b1) begin
      if (exp_out.size() == 0) begin
        chk("spurious_regwrite", {59'd0, WR}, 64'hFFFF);
      end else begin
        ent_t e;
        e = exp_out.pop_front();
        chk("out_WR", WR, e.a);
        chk("out_WD", WD, e.d);
      end
    end
  end

  task automatic step(input bit rst, input int rr1);
    ent_t ca, cl;
    bit ga, gl, ea, el, full_m, h;
    logic [DW-1:0] d;
    ca = '0;
    cl = '0;
    reset = rst;
    ga = !rst && alu_src.size() > 0 && (hold_a || $urandom_range(99) < pa);
    gl = !rst && ld_src.size() > 0 && (hold_l || $urandom_range(99) < pl);
    if (ga) ca = alu_src[0];
    if (gl) cl = ld_src[0];
    alu_valid = ga; alu_wr = ca.a; alu_wd = ca.d;
    ld_valid  = gl; ld_wr  = cl.a; ld_wd  = cl.d;
    byp_rr1 = (rr1 < 0) ? AW'($urandom_range(7)) : AW'(rr1);
    byp_rr2 = AW'($urandom_range(15));
    @(negedge clock);
    full_m = (mq.size() == DEPTH);
    ea = ga && !full_m && (!gl || !m_prio_ld);
    el = gl && !full_m && (!ga || m_prio_ld);
    if (!rst) begin
      chk("alu_ready", alu_ready, ea);
      chk("ld_ready", ld_ready, el);
      chk("full", full, full_m);
      chk("empty", empty, mq.size() == 0);
      byp_model(byp_rr1, h, d);
      chk("byp_hit1", byp_hit1, h);
      chk("byp_data1", byp_data1, d);
      byp_model(byp_rr2, h, d);
      chk("byp_hit2", byp_hit2, h);
      chk("byp_data2", byp_data2, d);
    end
    hold_a = ga && !alu_ready;
    hold_l = gl && !ld_ready;
    if (ga && alu_ready) void'(alu_src.pop_front());
    if (gl && ld_ready) void'(ld_src.pop_front());
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_out_vld = 0;
      m_prio_ld = 0;
    end else begin
      if (mq.size() > 0) begin
        m_out = mq.pop_front();
        m_out_vld = 1;
        exp_out.push_back(m_out);
      end else begin
        m_out_vld = 0;
      end
      if (ea && ca.a != 0) mq.push_back(ca);
      if (el && cl.a != 0) mq.push_back(cl);
      if (ga && gl && !full_m) m_prio_ld = !m_prio_ld;
    end
    #1;
  endtask

  initial begin
    reset = 1; alu_valid = 0; ld_valid = 0;
    alu_wr = '0; alu_wd = '0; ld_wr = '0; ld_wd = '0; byp_rr1 = '0; byp_rr2 = '0;
    step(1, 0);
    step(1, 0);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_WR", WR, 0);
    chk("rst_WD", WD, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);

    // Single ALU write: visible on the write port exactly two edges after acceptance.
    alu_src.push_back('{5'd5, 32'h11111111});
    step(0, 5);
    chk("lat_accepted", alu_src.size(), 0);
    chk("lat_edge1_rw", RegWrite, 0);
    chk("lat_edge1_empty", empty, 0);
    step(0, 5);
    chk("lat_edge2_rw", RegWrite, 1);
    chk("lat_edge2_WR", WR, 5);
    chk("lat_edge2_WD", WD, 32'h11111111);
    chk("lat_edge2_empty", empty, 1);
    step(0, -1);

    // Contested requests alternate grants.
    for (int i = 1; i <= 4; i++) begin
      alu_src.push_back('{AW'(i), 32'hA000_0000 + i});
      ld_src.push_back('{AW'(8 + i), 32'hB000_0000 + i});
    end
    for (int k = 0; k < 20 && (alu_src.size() > 0 || ld_src.size() > 0); k++) step(0, -1);
    chk("contest_drained", alu_src.size() + ld_src.size(), 0);
    repeat (3) step(0, -1);

    // Register 0 is handshaken and dropped.
    alu_src.push_back('{5'd0, 32'hDEADBEEF});
    step(0, 0);
    chk("r0_accepted", alu_src.size(), 0);
    repeat (3) step(0, 0);

    // Back-to-back writes to r7: bypass returns the youngest value.
    alu_src.push_back('{5'd7, 32'hA});
    alu_src.push_back('{5'd7, 32'hB});
    repeat (5) step(0, 7);

    // Reset with writes in flight discards everything.
    for (int i = 1; i <= 3; i++) alu_src.push_back('{AW'(i), 32'hC000_0000 + i});
    step(0, 1);
    step(0, 1);
    chk("pre_rst_rw", RegWrite, 1);
    chk("pre_rst_empty", empty, 0);
    step(1, 1);
    chk("post_rst_rw", RegWrite, 0);
    chk("post_rst_empty", empty, 1);
    for (int a = 1; a <= 3; a++) begin
      byp_rr1 = AW'(a);
      byp_rr2 = AW'(a);
      #1;
      chk("post_rst_hit1", byp_hit1, 0);
      chk("post_rst_hit2", byp_hit2, 0);
    end

    // Random traffic.
    pa = 60;
    pl = 60;
    for (int n = 0; n < 400; n++) begin
      if (alu_src.size() < 3 && $urandom_range(1) == 1)
        alu_src.push_back('{AW'($urandom_range(7)), $urandom});
      if (ld_src.size() < 3 && $urandom_range(1) == 1)
        ld_src.push_back('{AW'($urandom_range(7)), $urandom});
      step(0, -1);
    end

    pa = 100;
    pl = 100;
    for (int k = 0; k < 40 && (alu_src.size() > 0 || ld_src.size() > 0 || mq.size() > 0 || m_out_vld); k++)
      step(0, -1);
    step(0, -1);
    step(0, -1);
    chk("drain_src", alu_src.size() + ld_src.size(), 0);
    chk("drain_exp", exp_out.size(), 0);
    chk("drain_rw", RegWrite, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
